// File: rtl/av2_tile_scheduler.sv
// av2_tile_scheduler: walks a frame in raster tile order, launches the tile
// decoder for each tile, forwards that tile's bitstream words, and guards the
// wait for tile completion with a watchdog.
module av2_tile_scheduler #(
   parameter int unsigned TILE_LOG2      = 5,
   parameter int unsigned DATA_W         = 128,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   input  logic [15:0]       frame_width,
   input  logic [15:0]       frame_height,
   input  logic              abort,
   input  logic [DATA_W-1:0] bs_data,
   input  logic              bs_valid,
   input  logic              bs_last,
   output logic              bs_ready,
   output logic              dec_start,
   output logic [15:0]       dec_tile_x,
   output logic [15:0]       dec_tile_y,
   output logic [15:0]       dec_width,
   output logic [15:0]       dec_height,
   output logic [DATA_W-1:0] dec_data,
   output logic              dec_valid,
   input  logic              dec_ready,
   input  logic              dec_done,
   output logic              busy,
   output logic [15:0]       tile_count,
   output logic              frame_done,
   output logic              timeout_err
);

   localparam int unsigned TILE = 1 << TILE_LOG2;
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_FEED, S_WAIT_DONE, S_NEXT, S_DONE, S_ERR
   } state_t;

   state_t            state_q;
   logic [15:0]       fw_q, fh_q;
   logic [15:0]       tiles_x_q, tiles_y_q;
   logic [15:0]       x_q, y_q;
   logic [15:0]       x_d, y_d;
   logic              last_col, last_row;
   logic [WD_W-1:0]   wd_q;
   logic              wd_expire;
   logic              done_seen_q;
   logic              xfer;
   logic              feed;
   logic              dec_start_q, busy_q, frame_done_q, timeout_err_q;
   logic [15:0]       dec_tile_x_q, dec_tile_y_q, dec_width_q, dec_height_q;
   logic [15:0]       tile_count_q;

   // Number of tiles covering a dimension, rounded up in 17-bit arithmetic
   function automatic logic [15:0] ceil_tiles(input logic [15:0] dim);
      logic [16:0] sum;
      sum = 17'(dim) + 17'(TILE - 1);
      ceil_tiles = 16'(sum >> TILE_LOG2);
   endfunction

   // Tile edge clipped against the frame edge for tile index idx
   function automatic logic [15:0] clip_dim(input logic [15:0] dim, input logic [15:0] idx);
      logic [31:0] rem;
      rem = 32'(dim) - (32'(idx) << TILE_LOG2);
      clip_dim = (rem > 32'(TILE)) ? 16'(TILE) : 16'(rem);
   endfunction

   assign feed      = (state_q == S_FEED);
   assign xfer      = feed && bs_valid && dec_ready;
   assign wd_expire = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   // Upstream/decoder handshake is a straight wire while feeding, closed otherwise
   assign bs_ready  = feed && dec_ready;
   assign dec_valid = feed && bs_valid;
   assign dec_data  = feed ? bs_data : '0;

   assign dec_start   = dec_start_q;
   assign dec_tile_x  = dec_tile_x_q;
   assign dec_tile_y  = dec_tile_y_q;
   assign dec_width   = dec_width_q;
   assign dec_height  = dec_height_q;
   assign busy        = busy_q;
   assign tile_count  = tile_count_q;
   assign frame_done  = frame_done_q;
   assign timeout_err = timeout_err_q;

   // Raster advance: coordinates of the tile after the current one
   always_comb begin
      last_col = (x_q == tiles_x_q - 16'd1);
      last_row = (y_q == tiles_y_q - 16'd1);
      x_d      = x_q + 16'd1;
      y_d      = y_q;
      if (last_col) begin
         x_d = '0;
         y_d = y_q + 16'd1;
      end
   end

   // Frame sequencer, watchdog and registered decoder-side outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         fw_q          <= '0;
         fh_q          <= '0;
         tiles_x_q     <= '0;
         tiles_y_q     <= '0;
         x_q           <= '0;
         y_q           <= '0;
         wd_q          <= '0;
         done_seen_q   <= 1'b0;
         dec_start_q   <= 1'b0;
         dec_tile_x_q  <= '0;
         dec_tile_y_q  <= '0;
         dec_width_q   <= '0;
         dec_height_q  <= '0;
         busy_q        <= 1'b0;
         tile_count_q  <= '0;
         frame_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         dec_start_q  <= 1'b0;
         frame_done_q <= 1'b0;
         if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE, S_ERR: begin
                  if (frame_start) begin
                     fw_q          <= frame_width;
                     fh_q          <= frame_height;
                     tiles_x_q     <= ceil_tiles(frame_width);
                     tiles_y_q     <= ceil_tiles(frame_height);
                     tile_count_q  <= '0;
                     x_q           <= '0;
                     y_q           <= '0;
                     wd_q          <= '0;
                     done_seen_q   <= 1'b0;
                     timeout_err_q <= 1'b0;
                     busy_q        <= 1'b1;
                     if (frame_width == 16'd0 || frame_height == 16'd0) begin
                        state_q <= S_DONE;
                     end else begin
                        state_q      <= S_START;
                        dec_start_q  <= 1'b1;
                        dec_tile_x_q <= '0;
                        dec_tile_y_q <= '0;
                        dec_width_q  <= clip_dim(frame_width, 16'd0);
                        dec_height_q <= clip_dim(frame_height, 16'd0);
                     end
                  end
               end
               S_START: begin
                  state_q <= S_FEED;
                  wd_q    <= '0;
               end
               S_FEED: begin
                  if (xfer && bs_last) begin
                     wd_q <= '0;
                     if (done_seen_q || dec_done) begin
                        state_q <= S_NEXT;
                     end else begin
                        state_q <= S_WAIT_DONE;
                     end
                  end else begin
                     if (dec_done) begin
                        done_seen_q <= 1'b1;
                     end
                     if (xfer) begin
                        wd_q <= '0;
                     end else if (wd_expire && !dec_done) begin
                        state_q       <= S_ERR;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                     end else if (!wd_expire) begin
                        wd_q <= wd_q + 1'b1;
                     end
                  end
               end
               S_WAIT_DONE: begin
                  if (dec_done) begin
                     state_q <= S_NEXT;
                  end else if (wd_expire) begin
                     state_q       <= S_ERR;
                     busy_q        <= 1'b0;
                     timeout_err_q <= 1'b1;
                  end else begin
                     wd_q <= wd_q + 1'b1;
                  end
               end
               S_NEXT: begin
                  tile_count_q <= tile_count_q + 16'd1;
                  done_seen_q  <= 1'b0;
                  if (last_col && last_row) begin
                     state_q <= S_DONE;
                  end else begin
                     state_q      <= S_START;
                     x_q          <= x_d;
                     y_q          <= y_d;
                     dec_start_q  <= 1'b1;
                     dec_tile_x_q <= x_d;
                     dec_tile_y_q <= y_d;
                     dec_width_q  <= clip_dim(fw_q, x_d);
                     dec_height_q <= clip_dim(fh_q, y_d);
                  end
               end
               S_DONE: begin
                  state_q      <= S_IDLE;
                  busy_q       <= 1'b0;
                  frame_done_q <= 1'b1;
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_av2_tile_scheduler.sv
// tb_av2_tile_scheduler: randomized frames checked against a tile-list and
// word-queue reference built from the frame geometry.
module tb_av2_tile_scheduler;

   localparam int unsigned DATA_W   = 128;
   localparam int          TILE     = 32;
   localparam int          TO       = 1000;
   localparam int          DONE_DLY = 5;

   logic              clk;
   logic              rst_n;
   logic              frame_start;
   logic [15:0]       frame_width;
   logic [15:0]       frame_height;
   logic              abort;
   logic [DATA_W-1:0] bs_data;
   logic              bs_valid;
   logic              bs_last;
   logic              bs_ready;
   logic              dec_start;
   logic [15:0]       dec_tile_x;
   logic [15:0]       dec_tile_y;
   logic [15:0]       dec_width;
   logic [15:0]       dec_height;
   logic [DATA_W-1:0] dec_data;
   logic              dec_valid;
   logic              dec_ready;
   logic              dec_done;
   logic              busy;
   logic [15:0]       tile_count;
   logic              frame_done;
   logic              timeout_err;

   av2_tile_scheduler #(
      .TILE_LOG2      (5),
      .DATA_W         (DATA_W),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_start  (frame_start),
      .frame_width  (frame_width),
      .frame_height (frame_height),
      .abort        (abort),
      .bs_data      (bs_data),
      .bs_valid     (bs_valid),
      .bs_last      (bs_last),
      .bs_ready     (bs_ready),
      .dec_start    (dec_start),
      .dec_tile_x   (dec_tile_x),
      .dec_tile_y   (dec_tile_y),
      .dec_width    (dec_width),
      .dec_height   (dec_height),
      .dec_data     (dec_data),
      .dec_valid    (dec_valid),
      .dec_ready    (dec_ready),
      .dec_done     (dec_done),
      .busy         (busy),
      .tile_count   (tile_count),
      .frame_done   (frame_done),
      .timeout_err  (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int w;
      int h;
   } tile_t;

   tile_t             tq[$];
   logic [DATA_W-1:0] wq[$];
   bit                lq[$];
   int                checks = 0;
   int                errors = 0;

   // Single comparison point: counts and reports
   task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference tile list and word stream for a w x h frame
   task automatic build(input int w, input int h, input int wpt);
      int tx, ty, n;
      tq.delete();
      wq.delete();
      lq.delete();
      tx = (w + TILE - 1) / TILE;
      ty = (h + TILE - 1) / TILE;
      for (int y = 0; y < ty; y++) begin
         for (int x = 0; x < tx; x++) begin
            tile_t t;
            t.x = x;
            t.y = y;
            t.w = (w - x * TILE < TILE) ? (w - x * TILE) : TILE;
            t.h = (h - y * TILE < TILE) ? (h - y * TILE) : TILE;
            tq.push_back(t);
            n = (wpt == 0) ? int'($urandom_range(1, 4)) : wpt;
            for (int k = 0; k < n; k++) begin
               wq.push_back({$urandom, $urandom, $urandom, $urandom});
               lq.push_back(k == n - 1);
            end
         end
      end
   endtask

   // One frame: rmode 0 random ready, 1 toggling ready, 2 always ready
   task automatic run_frame(input int w, input int h, input int wpt, input int rmode,
                            input int hold_tile, input int abort_tile, input bit busy_fs);
      int cyc, starts, widx, cur, done_cnt, wait_cnt, fd_cyc, fd_cnt, last_done_cyc, tile_words;
      bit feeding, feed_next, stop, abort_now, aborted, fs_done, holding;
      build(w, h, wpt);
      starts = 0; widx = 0; cur = -1; done_cnt = -1; wait_cnt = -1;
      fd_cyc = -1; fd_cnt = 0; last_done_cyc = -1; tile_words = 0;
      feed_next = 1'b0; stop = 1'b0; aborted = 1'b0; fs_done = 1'b0; holding = 1'b0;
      abort_now = 1'b0;
      @(posedge clk);
      #1;
      frame_start  = 1'b1;
      frame_width  = 16'(w);
      frame_height = 16'(h);
      bs_valid     = 1'b0;
      dec_done     = 1'b0;
      abort        = 1'b0;
      @(posedge clk);
      cyc = 0;
      while (!stop && cyc < 20000) begin
         #1;
         frame_start = 1'b0;
         abort       = 1'b0;
         feeding     = feed_next;
         case (rmode)
            0:       dec_ready = 1'($urandom_range(0, 1));
            1:       dec_ready = (cyc % 2 == 1);
            default: dec_ready = 1'b1;
         endcase
         bs_valid = ($urandom_range(0, 3) != 0);
         if (widx < wq.size()) begin
            bs_data = wq[widx];
            bs_last = lq[widx];
         end else begin
            bs_data = {$urandom, $urandom, $urandom, $urandom};
            bs_last = 1'($urandom_range(0, 1));
         end
         dec_done = 1'b0;
         if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
               dec_done = 1'b1;
               done_cnt = -1;
            end
         end
         abort_now = (cur == abort_tile) && feeding && (tile_words >= 1);
         if (abort_now) begin
            abort    = 1'b1;
            bs_valid = 1'b0;
         end
         if (busy_fs && !fs_done && cur == 0 && feeding) begin
            frame_start  = 1'b1;
            frame_width  = 16'd16;
            frame_height = 16'd16;
            fs_done      = 1'b1;
         end
         @(negedge clk);
         if (dec_done) last_done_cyc = cyc;
         if (cyc == 0) chk("ts_clear", 128'(timeout_err), 128'(0));
         if (dec_start) begin
            if (starts < tq.size()) begin
               chk("tile_x", 128'(dec_tile_x), 128'(tq[starts].x));
               chk("tile_y", 128'(dec_tile_y), 128'(tq[starts].y));
               chk("tile_w", 128'(dec_width), 128'(tq[starts].w));
               chk("tile_h", 128'(dec_height), 128'(tq[starts].h));
               chk("tcnt_at_start", 128'(tile_count), 128'(starts));
            end else begin
               chk("extra_start", 128'(1), 128'(0));
            end
            chk("start_while_feed", 128'(feeding), 128'(0));
            cur        = starts;
            starts++;
            feed_next  = 1'b1;
            tile_words = 0;
         end
         chk("bs_ready", 128'(bs_ready), 128'(feeding && dec_ready));
         chk("dec_valid", 128'(dec_valid), 128'(feeding && bs_valid));
         if (holding) begin
            wait_cnt++;
            if (wait_cnt == TO - 1) begin
               chk("to_pre_err", 128'(timeout_err), 128'(0));
               chk("to_pre_busy", 128'(busy), 128'(1));
            end
            if (wait_cnt == TO) begin
               chk("to_err", 128'(timeout_err), 128'(1));
               chk("to_busy", 128'(busy), 128'(0));
               stop = 1'b1;
            end
         end
         if (feeding && bs_valid && dec_ready) begin
            if (widx < wq.size()) begin
               chk("dec_data", dec_data, wq[widx]);
               tile_words++;
               if (lq[widx]) begin
                  feed_next = 1'b0;
                  if (cur == hold_tile) begin
                     holding  = 1'b1;
                     wait_cnt = -1;
                  end else begin
                     done_cnt = DONE_DLY;
                  end
               end
               widx++;
            end else begin
               chk("extra_word", 128'(1), 128'(0));
            end
         end
         if (frame_done) begin
            fd_cnt++;
            if (fd_cyc < 0) fd_cyc = cyc;
            stop = 1'b1;
         end
         if (abort_now) begin
            aborted = 1'b1;
            stop    = 1'b1;
         end
         cyc++;
         @(posedge clk);
      end
      if (aborted) begin
         #1;
         abort     = 1'b0;
         dec_ready = 1'b1;
         bs_valid  = 1'b1;
         @(negedge clk);
         chk("ab_busy", 128'(busy), 128'(0));
         chk("ab_bs_ready", 128'(bs_ready), 128'(0));
         chk("ab_dec_valid", 128'(dec_valid), 128'(0));
         chk("ab_tcnt", 128'(tile_count), 128'(abort_tile));
         chk("ab_timeout", 128'(timeout_err), 128'(0));
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ab_no_done", 128'(frame_done), 128'(0));
            chk("ab_no_start", 128'(dec_start), 128'(0));
         end
      end else if (hold_tile >= 0) begin
         chk("to_reached", 128'(holding && wait_cnt == TO), 128'(1));
         chk("to_starts", 128'(starts), 128'(hold_tile + 1));
      end else begin
         chk("fd_seen", 128'(fd_cnt), 128'(1));
         chk("fd_tcnt", 128'(tile_count), 128'(tq.size()));
         chk("fd_starts", 128'(starts), 128'(tq.size()));
         chk("fd_words", 128'(widx), 128'(wq.size()));
         chk("fd_timeout", 128'(timeout_err), 128'(0));
         if (tq.size() == 0) chk("fd_lat_empty", 128'(fd_cyc), 128'(1));
         else                chk("fd_lat", 128'(fd_cyc - last_done_cyc), 128'(3));
         #1;
         bs_valid = 1'b0;
         @(negedge clk);
         chk("fd_pulse", 128'(frame_done), 128'(0));
         chk("fd_idle", 128'(busy), 128'(0));
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      frame_start  = 1'b1;
      frame_width  = 16'd64;
      frame_height = 16'd64;
      abort        = 1'b0;
      bs_data      = {$urandom, $urandom, $urandom, $urandom};
      bs_valid     = 1'b1;
      bs_last      = 1'b1;
      dec_ready    = 1'b1;
      dec_done     = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_start", 128'(dec_start), 128'(0));
      chk("rst_bs_ready", 128'(bs_ready), 128'(0));
      chk("rst_dec_valid", 128'(dec_valid), 128'(0));
      chk("rst_dec_data", dec_data, 128'(0));
      chk("rst_tcnt", 128'(tile_count), 128'(0));
      chk("rst_fdone", 128'(frame_done), 128'(0));
      chk("rst_timeout", 128'(timeout_err), 128'(0));
      chk("rst_geom", 128'({dec_tile_x, dec_tile_y, dec_width, dec_height}), 128'(0));
      frame_start = 1'b0;
      bs_valid    = 1'b0;
      dec_done    = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_frame(64, 64, 3, 2, -1, -1, 1'b0);
      run_frame(100, 40, 3, 2, -1, -1, 1'b0);
      run_frame(100, 40, 0, 1, -1, -1, 1'b0);
      run_frame(64, 64, 3, 2, 0, -1, 1'b0);
      run_frame(64, 64, 3, 2, -1, -1, 1'b0);
      run_frame(64, 64, 3, 1, -1, 1, 1'b1);
      run_frame(0, 50, 3, 2, -1, -1, 1'b0);
      run_frame(70, 0, 3, 2, -1, -1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         run_frame(int'($urandom_range(1, 130)), int'($urandom_range(1, 100)), 0,
                   int'($urandom_range(0, 1)), -1, -1, 1'b0);
      end
      run_frame(33, 1, 0, 0, -1, -1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
